// File: rtl/read_capture_fifo_pkg.sv
// Shared constants for the read-capture path and the register block it serves.
//   CAP_DATA_W : register read port width (captured word width)
//   CAP_DEPTH  : capture FIFO entries (power of two, >= 2)
//   CAP_PTR_W  : FIFO pointer width, log2(CAP_DEPTH)
//   CAP_CNT_W  : occupancy counter width, able to hold 0..CAP_DEPTH
package read_capture_fifo_pkg;

  localparam int unsigned CAP_DATA_W = 16;
  localparam int unsigned CAP_DEPTH  = 4;
  localparam int unsigned CAP_PTR_W  = $clog2(CAP_DEPTH);
  localparam int unsigned CAP_CNT_W  = CAP_PTR_W + 1;

endpackage : read_capture_fifo_pkg

// File: rtl/read_capture_fifo_if.sv
// Bundle of the capture FIFO's upstream read tap, consumer handshake and status.
//   master : drives rd_req/rd_data/clr_ovf/out_ready, observes FIFO outputs
//   slave  : the FIFO itself
interface read_capture_fifo_if
  import read_capture_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              clr_ovf;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              overflow;

  modport master (
    output rd_req, rd_data, clr_ovf, out_ready,
    input  out_valid, out_data, count, full, overflow
  );

  modport slave (
    input  rd_req, rd_data, clr_ovf, out_ready,
    output out_valid, out_data, count, full, overflow
  );

endinterface : read_capture_fifo_if

// File: rtl/capture_fifo_mem.sv
// DEPTH x DATA_W storage for the capture FIFO: one write port, one async read port.
//   clk, reset : clock and async active-low reset (clears every entry to zero)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational read port
module capture_fifo_mem
  import read_capture_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array; cleared so out_data reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : capture_fifo_mem

// File: rtl/read_capture_fifo.sv
// Captures register read data one cycle after each issued read and queues it
// for a consumer (first-word fall-through). Drops words when full, flagging a
// sticky overflow.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of read_capture_fifo_if
//           rd_req/rd_data : upstream read tap (data valid the cycle after rd_req)
//           clr_ovf        : clears sticky overflow (a same-cycle drop wins)
//           out_ready/out_valid/out_data : consumer handshake, oldest word
//           count/full/overflow          : status
module read_capture_fifo
  import read_capture_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  read_capture_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             cap_pend_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;

  logic              pop_c;
  logic              accept_c;
  logic              drop_c;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state: a pop frees a slot in the same cycle, so a full FIFO still
  // accepts a capture that coincides with a pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    pop_c    = valid_q & bus.out_ready;
    accept_c = cap_pend_q & (~full_q | pop_c);
    drop_c   = cap_pend_q & full_q & ~pop_c;

    if (accept_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({accept_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end

    // Status flags tracked as flops that always equal their count decode.
    valid_d = (count_d != '0);
    full_d  = (count_d == FULL_CNT);
  end

  // State register; cap_pend mirrors the upstream one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      cap_pend_q <= bus.rd_req;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
    end
  end

  capture_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (accept_c),
    .waddr (wr_ptr_q),
    .wdata (bus.rd_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_data  = mem_rdata;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;

endmodule : read_capture_fifo

// File: tb/tb_read_capture_fifo.sv
// Scoreboard bench for read_capture_fifo (DATA_W=16, DEPTH=4).
module tb_read_capture_fifo;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  read_capture_fifo_if bus ();

  read_capture_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: expected FIFO contents, pending capture, sticky flag.
  logic [15:0] exp_q[$];
  bit          m_pend;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk({tag, "_full"}, 32'(bus.full), 32'(exp_q.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, "_nox"}, 32'($isunknown(bus.out_data)), 32'd0);
    if (exp_q.size() != 0) begin
      chk({tag, "_head"}, 32'(bus.out_data), 32'(exp_q[0]));
    end
  endtask

  // One clock: drive inputs, update the reference, check after the edge.
  task automatic cyc(input bit rq, input logic [15:0] d, input bit rdy, input bit clr);
    logic [15:0] popped;
    bit drop;
    bus.rd_req    = rq;
    bus.rd_data   = d;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    drop = 1'b0;
    if (rdy && exp_q.size() != 0) begin
      popped = exp_q.pop_front();
      chk("pop_data", 32'(bus.out_data), 32'(popped));
    end
    if (m_pend) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_pend = rq;
    tick();
    chk_state("cyc");
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_data   = '0;
    bus.clr_ovf   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    reset = 1'b1;

    // Single read: data lands two edges after rd_req, no bypass
    cyc(1'b1, 16'hxxxx, 1'b0, 1'b0);
    chk("r31_nobypass", 32'(bus.out_valid), 32'd0);
    cyc(1'b0, 16'hA5A5, 1'b0, 1'b0);
    chk("r31_valid", 32'(bus.out_valid), 32'd1);
    chk("r31_data", 32'(bus.out_data), 32'h0000A5A5);
    chk("r31_count", 32'(bus.count), 32'd1);
    cyc(1'b0, 16'hxxxx, 1'b1, 1'b0);

    // Idle with X data, plus out_ready while empty
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'hxxxx, i[0], 1'b0);
    chk("r32_count", 32'(bus.count), 32'd0);

    // Five back-to-back captures into a 4-deep FIFO
    cyc(1'b1, 16'hxxxx, 1'b0, 1'b0);
    for (int v = 1; v <= 4; v++) cyc(1'b1, 16'(v), 1'b0, 1'b0);
    cyc(1'b0, 16'd5, 1'b0, 1'b0);
    chk("r33_count", 32'(bus.count), 32'd4);
    chk("r33_full", 32'(bus.full), 32'd1);
    chk("r33_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'hxxxx, 1'b1, 1'b0);
    chk("r33_empty", 32'(bus.out_valid), 32'd0);
    cyc(1'b0, 16'hxxxx, 1'b0, 1'b1);

    // Capture into full FIFO while popping
    cyc(1'b1, 16'hxxxx, 1'b0, 1'b0);
    for (int v = 0; v < 4; v++) cyc(1'b1, 16'(16'h11 + v), 1'b0, 1'b0);
    cyc(1'b0, 16'h0007, 1'b1, 1'b0);
    chk("r34_count", 32'(bus.count), 32'd4);
    chk("r34_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'hxxxx, 1'b1, 1'b0);

    // Overflow set beats clear; clear alone then works
    cyc(1'b1, 16'hxxxx, 1'b0, 1'b0);
    for (int v = 0; v < 5; v++) cyc(1'b1, 16'(16'h31 + v), 1'b0, 1'b0);
    chk("r35_set", 32'(bus.overflow), 32'd1);
    cyc(1'b0, 16'h0036, 1'b0, 1'b1);
    chk("r35_setwins", 32'(bus.overflow), 32'd1);
    cyc(1'b0, 16'hxxxx, 1'b0, 1'b1);
    chk("r35_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'hxxxx, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'hxxxx, 1'b1, 1'b0);

    // Mid-cycle reset with three words stored and a capture pending
    cyc(1'b1, 16'hxxxx, 1'b0, 1'b0);
    for (int v = 0; v < 3; v++) cyc(1'b1, 16'(16'h21 + v), 1'b0, 1'b0);
    chk("r36_pre", 32'(bus.count), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("r36_count", 32'(bus.count), 32'd0);
    chk("r36_valid", 32'(bus.out_valid), 32'd0);
    chk("r36_data", 32'(bus.out_data), 32'd0);
    model_reset();
    bus.rd_req = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0099, 1'b0, 1'b0);
    chk("r36_nocap", 32'(bus.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_read_capture_fifo
